// File: rtl/snd_pkg.sv
// snd_pkg: shared types and defaults for the sound sample unpacker.
package snd_pkg;
   localparam int DW_DEF      = 16;
   localparam int AW_DEF      = 3;
   localparam int PREFILL_DEF = 4;
   localparam int FRAME_BYTES = 4;
   typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} byte_st_t;
   typedef enum logic {FILL = 1'b0, RUN = 1'b1} play_st_t;
endpackage

// File: rtl/snd_word_fifo.sv
// snd_word_fifo: show-ahead synchronous word FIFO with sync clear.
module snd_word_fifo #(
   parameter int W  = 32,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;
   // a push into a full FIFO only lands when a pop frees the slot in the same cycle
   assign wr    = push && (!full || pop);
   assign rd    = pop && !empty;
   assign full  = count[AW];
   assign empty = count == '0;
   assign dout  = mem[rp];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (clr) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      end
   always_ff @(posedge clk)
      if (wr) mem[wp] <= din;
endmodule

// File: rtl/snd_sample_unpack.sv
// snd_sample_unpack: assembles 4-byte frames into stereo samples and
// releases them one per sample tick after a FIFO prefill.
module snd_sample_unpack
   import snd_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int AW      = AW_DEF,
   parameter int PREFILL = PREFILL_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          aclr,
   input  logic          byte_vld,
   input  logic [7:0]    byte_in,
   input  logic          smp_tick,
   output logic [DW-1:0] smp_l,
   output logic [DW-1:0] smp_r,
   output logic          smp_vld,
   output logic [AW:0]   fifo_cnt,
   output logic          ovf,
   output logic          unf,
   output logic          playing
);
   byte_st_t        bst;
   play_st_t        pst;
   logic [DW-1:0]   l;
   logic [7:0]      r_lo;
   logic            push, pop, full, empty;
   logic [2*DW-1:0] word, dout;
   assign push    = byte_vld && bst == B3;
   assign pop     = pst == RUN && smp_tick && !empty;
   assign word    = {l, byte_in, r_lo};
   assign playing = pst == RUN;
   snd_word_fifo #(.W(2*DW), .AW(AW)) u_fifo (
      .clk(clk), .reset_n(reset_n), .clr(aclr), .push(push), .pop(pop),
      .din(word), .dout(dout), .full(full), .empty(empty), .count(fifo_cnt)
   );
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         bst     <= B0;
         pst     <= FILL;
         l       <= '0;
         r_lo    <= '0;
         smp_l   <= '0;
         smp_r   <= '0;
         smp_vld <= 1'b0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else if (aclr) begin
         bst     <= B0;
         pst     <= FILL;
         l       <= '0;
         r_lo    <= '0;
         smp_l   <= '0;
         smp_r   <= '0;
         smp_vld <= 1'b0;
         ovf     <= 1'b0;
         unf     <= 1'b0;
      end else begin
         if (byte_vld) begin
            bst <= byte_st_t'(bst + 2'd1);
            if (bst == B0) l[7:0]  <= byte_in;
            if (bst == B1) l[15:8] <= byte_in;
            if (bst == B2) r_lo    <= byte_in;
         end
         if (push && full && !pop) ovf <= 1'b1;
         smp_vld <= pop;
         if (pop) {smp_l, smp_r} <= dout;
         // an empty tick in RUN falls back to prefill rather than replaying stale data
         if (pst == RUN && smp_tick && empty) begin
            unf <= 1'b1;
            pst <= FILL;
         end else if (pst == FILL && fifo_cnt >= (AW+1)'(PREFILL))
            pst <= RUN;
      end
endmodule

// File: tb/tb_snd_sample_unpack.sv
// tb_snd_sample_unpack: directed vectors with hand-computed expectations.
module tb_snd_sample_unpack;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        aclr = 1'b0;
   logic        byte_vld = 1'b0;
   logic [7:0]  byte_in = '0;
   logic        smp_tick = 1'b0;
   logic [15:0] smp_l, smp_r;
   logic        smp_vld, ovf, unf, playing;
   logic [3:0]  fifo_cnt;
   int          n_vec = 0;
   int          n_err = 0;
   always #5 clk = ~clk;
   snd_sample_unpack dut (
      .clk(clk), .reset_n(reset_n), .aclr(aclr), .byte_vld(byte_vld),
      .byte_in(byte_in), .smp_tick(smp_tick), .smp_l(smp_l), .smp_r(smp_r),
      .smp_vld(smp_vld), .fifo_cnt(fifo_cnt), .ovf(ovf), .unf(unf),
      .playing(playing)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic send_byte(input logic [7:0] b);
      byte_vld = 1'b1;
      byte_in  = b;
      cyc();
      byte_vld = 1'b0;
   endtask
   task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
      send_byte(l[7:0]);
      send_byte(l[15:8]);
      send_byte(r[7:0]);
      send_byte(r[15:8]);
   endtask
   task automatic tick();
      smp_tick = 1'b1;
      cyc();
      smp_tick = 1'b0;
   endtask
   task automatic do_aclr();
      aclr = 1'b1;
      cyc();
      aclr = 1'b0;
   endtask
   task automatic chk_smp(input string tag, input logic [15:0] l, input logic [15:0] r, input logic v);
      chk({tag, "_l"}, 32'(smp_l), 32'(l));
      chk({tag, "_r"}, 32'(smp_r), 32'(r));
      chk({tag, "_vld"}, 32'(smp_vld), 32'(v));
   endtask
   initial begin
      #12;
      chk("rst_outs", {smp_l, smp_r}, 32'h0);
      chk("rst_flags", {26'd0, smp_vld, ovf, unf, playing, fifo_cnt[1:0]}, 32'h0);
      chk("rst_cnt", 32'(fifo_cnt), 32'd0);
      reset_n = 1'b1;
      cyc();
      // prefill and first sample
      for (int i = 0; i < 3; i++) send_frame(16'h1234, 16'h5678);
      chk("pre_cnt3", 32'(fifo_cnt), 32'd3);
      chk("pre_play3", 32'(playing), 32'd0);
      send_frame(16'h1234, 16'h5678);
      chk("pre_cnt4", 32'(fifo_cnt), 32'd4);
      cyc();
      chk("pre_play", 32'(playing), 32'd1);
      tick();
      chk_smp("first", 16'h1234, 16'h5678, 1'b1);
      chk("first_cnt", 32'(fifo_cnt), 32'd3);
      cyc();
      chk("vld_pulse", 32'(smp_vld), 32'd0);
      // underflow: three more pops then an empty tick
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drain_vld", 32'(smp_vld), 32'd1);
      end
      chk("drain_cnt", 32'(fifo_cnt), 32'd0);
      tick();
      chk_smp("unf_hold", 16'h1234, 16'h5678, 1'b0);
      chk("unf_flag", 32'(unf), 32'd1);
      chk("unf_play", 32'(playing), 32'd0);
      // partial frame discarded by aclr
      send_byte(8'hAA);
      send_byte(8'hBB);
      do_aclr();
      chk("aclr_outs", {smp_l, smp_r}, 32'h0);
      chk("aclr_flags", {unf, ovf, playing, fifo_cnt}, 32'h0);
      send_frame(16'h0001, 16'h0002);
      for (int i = 3; i < 9; i += 2) send_frame(16'(i), 16'(i + 1));
      cyc();
      tick();
      chk_smp("aclr_first", 16'h0001, 16'h0002, 1'b1);
      chk("aclr_f", {ovf, unf}, 32'h0);
      // overflow: nine frames, no ticks
      do_aclr();
      for (int i = 0; i < 9; i++) send_frame(16'h1100 + 16'(i), 16'h2200 + 16'(i));
      chk("ovf_cnt", 32'(fifo_cnt), 32'd8);
      chk("ovf_flag", 32'(ovf), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk_smp("ovf_drain", 16'h1100 + 16'(i), 16'h2200 + 16'(i), 1'b1);
      end
      chk("ovf_empty", 32'(fifo_cnt), 32'd0);
      tick();
      chk_smp("ovf_9th", 16'h1107, 16'h2207, 1'b0);
      chk("ovf_unf", 32'(unf), 32'd1);
      // full with simultaneous push and pop
      do_aclr();
      for (int i = 0; i < 8; i++) send_frame(16'h3300 + 16'(i), 16'h4400 + 16'(i));
      chk("fp_play", 32'(playing), 32'd1);
      send_byte(8'h08);
      send_byte(8'h33);
      send_byte(8'h08);
      byte_vld = 1'b1;
      byte_in  = 8'h44;
      smp_tick = 1'b1;
      cyc();
      byte_vld = 1'b0;
      smp_tick = 1'b0;
      chk("fp_cnt", 32'(fifo_cnt), 32'd8);
      chk("fp_ovf", 32'(ovf), 32'd0);
      chk_smp("fp_pop", 16'h3300, 16'h4400, 1'b1);
      for (int i = 1; i < 9; i++) begin
         tick();
         chk_smp("fp_order", 16'h3300 + 16'(i), 16'h4400 + 16'(i), 1'b1);
      end
      // async reset mid-frame
      send_frame(16'h7777, 16'h8888);
      send_byte(8'h11);
      send_byte(8'h22);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_outs", {smp_l, smp_r}, 32'h0);
      chk("arst_flags", {unf, ovf, playing, smp_vld, fifo_cnt}, 32'h0);
      #2 reset_n = 1'b1;
      cyc();
      send_frame(16'hBEEF, 16'hDEAD);
      for (int i = 0; i < 3; i++) send_frame(16'h5000 + 16'(i), 16'h6000 + 16'(i));
      chk("arst_cnt", 32'(fifo_cnt), 32'd4);
      cyc();
      tick();
      chk_smp("arst_first", 16'hBEEF, 16'hDEAD, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/snd_sample_unpack.md
Name: snd_sample_unpack

Overview:
Downstream consumer of the sync-gated 4-byte shift FIFO in the sound path. It takes that stage's byte stream (rd_ena strobe plus r_data byte) and assembles 4-byte frames into stereo 16-bit samples. Samples are buffered in a small word FIFO and released to the DAC side, one per sample-rate tick, after an initial prefill.

Parameters:
DW, 16, sample width per channel; frame is 2*DW/8 bytes, fixed at 4 bytes for DW=16
AW, 3, word FIFO address width; depth = 2**AW words of 2*DW bits
PREFILL, 4, FIFO occupancy required before playback starts (1..2**AW)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
aclr  in  1  synchronous clear, same meaning as the upstream stage's aclr
byte_vld  in  1  one-cycle strobe; byte_in is valid (driven by upstream rd_ena)
byte_in  in  8  stream byte (driven by upstream r_data)
smp_tick  in  1  one-cycle sample-rate strobe from the DAC clocking logic
smp_l  out  DW  left sample, registered
smp_r  out  DW  right sample, registered
smp_vld  out  1  one-cycle pulse; smp_l/smp_r were updated from the FIFO
fifo_cnt  out  AW+1  current word FIFO occupancy, 0..2**AW
ovf  out  1  sticky: a complete frame was dropped because the FIFO was full
unf  out  1  sticky: a tick in RUN found the FIFO empty
playing  out  1  high while the playback FSM is in RUN

Behaviour:
- Reset (reset_n low, async): all outputs 0; byte FSM in B0; play FSM in FILL; FIFO empty.
- aclr (sync) has priority over every other input. Effects: same state as reset; any partially assembled frame is discarded; sticky flags are cleared.
- Byte FSM, advancing only on byte_vld:
  - B0 captures L[7:0], B1 captures L[15:8], B2 captures R[7:0], B3 captures R[15:8].
  - B3 returns to B0 and issues a push of {L,R} in the same cycle.
  - byte_vld low: state and partial data hold. There is no timeout.
- Push when the FIFO is full and no pop happens in that cycle: the word is dropped, ovf is set, and the FSM still returns to B0.
- Push and pop in the same cycle while full: both succeed and fifo_cnt is unchanged.
- Play FSM:
  - FILL: smp_tick is ignored (no pop, no unf). Transition to RUN when fifo_cnt >= PREFILL, evaluated every cycle.
  - RUN, smp_tick with FIFO not empty: pop; smp_l/smp_r take the word on the next edge; smp_vld is 1 for that cycle. Latency from tick to smp_vld is 1 clk.
  - RUN, smp_tick with FIFO empty: no pop; set unf; smp_l/smp_r hold their last values; smp_vld stays 0; go to FILL.
  - Push and tick in the same cycle while empty: the tick sees empty (no bypass) and the push is accepted.
- playing = (state == RUN), registered.
- FIFO pointers are AW bits and wrap modulo 2**AW. Count is AW+1 bits. Full when count == 2**AW; empty when count == 0.
- Byte order is little-endian within each channel, left channel first. No sign conversion; bytes are passed through bit-exact.

Decomposition:
- Shared package snd_pkg:
  - byte-FSM state type with B0..B3 encodings
  - play-FSM state type (FILL, RUN)
  - FRAME_BYTES = 4 constant
  - default DW/AW/PREFILL constants
- Sub-module snd_word_fifo: synchronous FIFO, width 2*DW, depth 2**AW.
  - Inputs: push, pop, clr. Outputs: dout (show-ahead), full, empty, count.
  - Reset is async active-low; clr is synchronous.
  - Top level holds the two FSMs, the output registers and the sticky flags.

Test Plan:
- Prefill and first sample: send frames 0x34,0x12,0x78,0x56 four times (AW=3, PREFILL=4). playing rises once fifo_cnt=4. At the next tick, smp_l=0x1234 and smp_r=0x5678 one clk later with a smp_vld pulse, and fifo_cnt=3.
- Overflow: push 9 frames with no ticks. fifo_cnt saturates at 8, ovf=1, and the 9th word is absent when the FIFO is drained.
- Underflow: reach RUN with 4 words, then issue 5 ticks. The first 4 ticks produce smp_vld. The 5th sets unf=1, leaves smp_vld=0, holds the last sample, and returns playing to 0.
- Partial frame then aclr: send 2 bytes, pulse aclr, then send 0x01,0x00,0x02,0x00 (plus 3 more frames to reach prefill). The first output is smp_l=0x0001 and smp_r=0x0002, and the flags are 0.
- Full with simultaneous push and pop: in RUN with fifo_cnt=8, the 4th byte_vld coincides with smp_tick. fifo_cnt stays 8, ovf stays 0, and FIFO order is preserved.
- Async reset mid-frame: drop reset_n between clk edges. All outputs go to 0 immediately, and the next 4 bytes are captured as a fresh frame.
